// File: rtl/spi_cs_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_cs_arbiter
// Purpose  : Round-robin arbiter that hands one SPI master to NUM_REQ clients,
//            one chip-select burst at a time.
// Revision : 1.0
// ============================================================================
module spi_cs_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int MAX_BYTES_PER_CS = 7,
  parameter int CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*CNT_W-1:0] i_count,
  input  logic [NUM_REQ*8-1:0]     i_tx_byte,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_byte_ack,
  output logic [7:0]               o_rx_byte,
  output logic [NUM_REQ-1:0]       o_rx_valid,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [7:0]               o_m_tx_byte,
  output logic                     o_m_tx_en,
  output logic [CNT_W-1:0]         o_m_tx_count,
  input  logic                     i_m_tx_ready,
  input  logic [7:0]               i_m_rx_byte,
  input  logic                     i_m_rx_en
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_RDY  = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BYTES_PER_CS);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nx;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last_grant;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   r_tx_count;
  logic [7:0]         r_rx_byte;
  logic [NUM_REQ-1:0] r_rx_valid;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_k;
  logic [CNT_W-1:0]   w_pick_cnt;
  logic [CNT_W-1:0]   w_clamped;
  logic [CNT_W-1:0]   w_rem_dec;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_grant_now;

  // A zero-length request can never start a burst, so it is not eligible.
  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
      assign w_elig[g] = i_req[g] & (|i_count[g*CNT_W +: CNT_W]);
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_k     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = IDX_W'((int'(r_last_grant) + i) % NUM_REQ);
      if (!w_found && w_elig[w_k]) begin
        w_found = 1'b1;
        w_pick  = w_k;
      end
    end
  end

  assign w_pick_cnt  = i_count[w_pick*CNT_W +: CNT_W];
  assign w_clamped   = (w_pick_cnt > C_MAX) ? C_MAX : w_pick_cnt;
  assign w_rem_dec   = r_remaining - CNT_W'(1);
  assign w_owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_grant_now = (r_state == S_IDLE) && (w_state_nx == S_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:      if (i_m_tx_ready && w_found) w_state_nx = S_SEND;
      S_SEND:      w_state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!i_m_tx_ready) w_state_nx = S_WAIT_RDY;
      S_WAIT_RDY:  if (i_m_tx_ready) w_state_nx = (w_rem_dec != '0) ? S_SEND : S_DONE;
      S_DONE:      w_state_nx = S_IDLE;
      default:     w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    o_grant     = '0;
    o_byte_ack  = '0;
    o_done      = '0;
    o_m_tx_en   = 1'b0;
    o_m_tx_byte = 8'h00;
    if (r_state != S_IDLE) o_grant = w_owner_oh;
    if (r_state == S_SEND) begin
      o_m_tx_en   = 1'b1;
      o_m_tx_byte = i_tx_byte[r_owner*8 +: 8];
      o_byte_ack  = w_owner_oh;
    end
    if (r_state == S_DONE) o_done = w_owner_oh;
  end

  // Burst bookkeeping; owner and length are frozen at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_remaining  <= '0;
      r_tx_count   <= '0;
      r_rx_byte    <= 8'h00;
      r_rx_valid   <= '0;
    end else begin
      if (w_grant_now) begin
        r_owner     <= w_pick;
        r_remaining <= w_clamped;
        r_tx_count  <= w_clamped;
      end
      if (r_state == S_WAIT_RDY && i_m_tx_ready) r_remaining <= w_rem_dec;
      if (r_state == S_DONE) r_last_grant <= r_owner;
      if (i_m_rx_en && r_state != S_IDLE) begin
        r_rx_byte  <= i_m_rx_byte;
        r_rx_valid <= w_owner_oh;
      end else begin
        r_rx_valid <= '0;
      end
    end
  end

  assign o_m_tx_count = r_tx_count;
  assign o_rx_byte    = r_rx_byte;
  assign o_rx_valid   = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_cs_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_cs_arbiter
// Purpose  : Self-checking bench for spi_cs_arbiter with a loopback SPI master.
// Revision : 1.0
// ============================================================================
module tb_spi_cs_arbiter;
  localparam int NR = 4, MAXB = 7, CW = 4;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0] req = '0;
  logic [NR*CW-1:0] count_v;
  logic [NR*8-1:0] txb_v;
  logic [CW-1:0] cnt [NR];
  logic [7:0] base [NR];
  logic [7:0] ptr [NR];

  logic [NR-1:0] o_grant, o_byte_ack, o_rx_valid, o_done;
  logic [7:0] o_rx_byte, o_m_tx_byte;
  logic o_m_tx_en;
  logic [CW-1:0] o_m_tx_count;

  logic m_ready = 1'b1, m_rx_en = 1'b0, inj = 1'b0;
  logic [7:0] m_rx_byte = 8'h00, m_lat = 8'h00;
  int m_busy = 0;
  wire w_rx_en = m_rx_en | inj;
  wire [7:0] w_rx_byte = inj ? 8'hEE : m_rx_byte;

  int checks = 0, errors = 0;
  int exp_q[$];

  int grant_n, rx_n, done_total, txen_n, rxv_n, oh_err = 0, gap_err = 0, gap = 100;
  int grant_log[32], rx_idx[32], ack_cnt[NR], done_cnt[NR];
  logic [7:0] rx_b[32];
  logic [CW-1:0] last_txcount;
  logic [NR-1:0] prev_grant = '0;

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      count_v[k*CW +: CW] = cnt[k];
      txb_v[k*8 +: 8] = base[k] + ptr[k];
    end
  end

  spi_cs_arbiter #(.NUM_REQ(NR), .MAX_BYTES_PER_CS(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_count(count_v), .i_tx_byte(txb_v),
    .o_grant(o_grant), .o_byte_ack(o_byte_ack), .o_rx_byte(o_rx_byte),
    .o_rx_valid(o_rx_valid), .o_done(o_done), .o_m_tx_byte(o_m_tx_byte),
    .o_m_tx_en(o_m_tx_en), .o_m_tx_count(o_m_tx_count), .i_m_tx_ready(m_ready),
    .i_m_rx_byte(w_rx_byte), .i_m_rx_en(w_rx_en)
  );

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[k]) return k;
    return 0;
  endfunction

  // Loopback master: busy for three cycles per byte, then echoes it back.
  always @(negedge clk) begin
    m_rx_en = 1'b0;
    if (rst) begin
      m_busy = 0; m_ready = 1'b1;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_ready = 1'b1; m_rx_en = 1'b1; m_rx_byte = m_lat; end
    end else if (o_m_tx_en) begin
      m_lat = o_m_tx_byte; m_ready = 1'b0; m_busy = 3;
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < NR; k++) ptr[k] <= 8'h00;
    end else if (|o_byte_ack) begin
      ptr[oh2i(o_byte_ack)] <= ptr[oh2i(o_byte_ack)] + 8'h01;
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      grant_n = 0; rx_n = 0; done_total = 0; txen_n = 0; rxv_n = 0;
      for (int k = 0; k < NR; k++) begin ack_cnt[k] = 0; done_cnt[k] = 0; end
    end else begin
      if (o_grant != '0 && prev_grant == '0 && grant_n < 32) begin
        grant_log[grant_n] = oh2i(o_grant); grant_n++;
      end
      if (|o_byte_ack) ack_cnt[oh2i(o_byte_ack)]++;
      if (|o_done) begin done_cnt[oh2i(o_done)]++; done_total++; end
      if (o_m_tx_en) begin txen_n++; last_txcount = o_m_tx_count; end
      if (|o_rx_valid) begin
        rxv_n++;
        if (rx_n < 32) begin rx_idx[rx_n] = oh2i(o_rx_valid); rx_b[rx_n] = o_rx_byte; rx_n++; end
      end
    end
    prev_grant = o_grant;
    gap++;
    if (o_m_tx_en) begin if (gap < 3) gap_err++; gap = 0; end
    if ($countones(o_grant) > 1 || $countones(o_byte_ack) > 1 ||
        $countones(o_rx_valid) > 1 || $countones(o_done) > 1) oh_err++;
  end

  task automatic tick(); @(negedge clk); #1; endtask

  task automatic clear_obs(); clr = 1'b1; tick(); tick(); clr = 1'b0; endtask

  task automatic wait_grants(input int n, input string nm);
    bit to = 1'b1;
    for (int i = 0; i < 300; i++) begin tick(); if (grant_n >= n) begin to = 1'b0; break; end end
    checks++;
    if (to) begin errors++; $display("FAIL %s_grant_timeout: got %0d grants required %0d", nm, grant_n, n); end
  endtask

  task automatic wait_done(input int n, input string nm);
    bit to = 1'b1;
    for (int i = 0; i < 600; i++) begin tick(); if (done_total >= n) begin to = 1'b0; break; end end
    tick(); tick();
    checks++;
    if (to) begin errors++; $display("FAIL %s_done_timeout: got %0d done required %0d", nm, done_total, n); end
  endtask

  task automatic check_rx(input string nm);
    int i = 0;
    checks++;
    if (rx_n !== exp_q.size()) begin
      errors++; $display("FAIL %s_rx_count: got %0d required %0d", nm, rx_n, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      int e = exp_q.pop_front();
      checks++;
      if (i >= rx_n || (rx_idx[i]*256 + int'(rx_b[i])) !== e) begin
        errors++;
        $display("FAIL %s_rx[%0d]: got %0h required %0h", nm, i, (i < rx_n) ? rx_idx[i]*256 + int'(rx_b[i]) : -1, e);
      end
      i++;
    end
  endtask

  task automatic check_all_zero(input string nm);
    checks++;
    if ({o_grant, o_byte_ack, o_rx_valid, o_done} !== '0) begin
      errors++; $display("FAIL %s_ctrl: got %h required 0", nm, {o_grant, o_byte_ack, o_rx_valid, o_done});
    end
    checks++;
    if ({o_m_tx_en, o_m_tx_byte, o_m_tx_count, o_rx_byte} !== '0) begin
      errors++; $display("FAIL %s_data: got %h required 0", nm, {o_m_tx_en, o_m_tx_byte, o_m_tx_count, o_rx_byte});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0; clr = 1'b0;
    tick();
  endtask

  task automatic test_single();
    clear_obs();
    base[0] = 8'h01; cnt[0] = 4'd3; req[0] = 1'b1;
    for (int b = 1; b <= 3; b++) exp_q.push_back(0*256 + b);
    wait_grants(1, "single");
    req[0] = 1'b0;
    wait_done(1, "single");
    checks++; if (last_txcount !== 4'd3) begin errors++; $display("FAIL single_tx_count: got %0d required 3", last_txcount); end
    checks++; if (ack_cnt[0] !== 3) begin errors++; $display("FAIL single_acks: got %0d required 3", ack_cnt[0]); end
    checks++; if (done_cnt[0] !== 1) begin errors++; $display("FAIL single_done: got %0d required 1", done_cnt[0]); end
    check_rx("single");
  endtask

  task automatic test_round_robin();
    rst = 1'b1; clr = 1'b1; tick(); tick(); rst = 1'b0; clr = 1'b0;
    cnt[0] = 4'd1; cnt[2] = 4'd1; req[0] = 1'b1; req[2] = 1'b1;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
    wait_grants(4, "rr");
    cnt[1] = 4'd1; req[1] = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    wait_grants(7, "rr");
    req = '0;
    wait_done(7, "rr");
    checks++; if (grant_n !== 7) begin errors++; $display("FAIL rr_grant_count: got %0d required 7", grant_n); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      int e = exp_q.pop_front();
      checks++;
      if (grant_log[i] !== e) begin errors++; $display("FAIL rr_order[%0d]: got %0d required %0d", i, grant_log[i], e); end
    end
  endtask

  task automatic test_count_bounds();
    clear_obs();
    cnt[3] = 4'd0; req[3] = 1'b1;
    repeat (20) tick();
    checks++; if (grant_n !== 0) begin errors++; $display("FAIL zero_count_grant: got %0d grants required 0", grant_n); end
    req[3] = 1'b0;
    clear_obs();
    base[1] = 8'h40; cnt[1] = 4'd9; req[1] = 1'b1;
    for (int b = 0; b < 7; b++) exp_q.push_back(1*256 + 'h40 + b);
    wait_grants(1, "clamp");
    req[1] = 1'b0;
    wait_done(1, "clamp");
    checks++; if (last_txcount !== 4'd7) begin errors++; $display("FAIL clamp_tx_count: got %0d required 7", last_txcount); end
    checks++; if (txen_n !== 7) begin errors++; $display("FAIL clamp_tx_en: got %0d required 7", txen_n); end
    checks++; if (done_cnt[1] !== 1) begin errors++; $display("FAIL clamp_done: got %0d required 1", done_cnt[1]); end
    check_rx("clamp");
  endtask

  task automatic test_mid_drop();
    bit to = 1'b1;
    clear_obs();
    base[2] = 8'h80; cnt[2] = 4'd4; req[2] = 1'b1;
    for (int b = 0; b < 4; b++) exp_q.push_back(2*256 + 'h80 + b);
    for (int i = 0; i < 200; i++) begin tick(); if (ack_cnt[2] >= 1) begin to = 1'b0; break; end end
    checks++; if (to) begin errors++; $display("FAIL drop_first_ack: got 0 acks required 1"); end
    req[2] = 1'b0; cnt[2] = 4'd1;
    wait_done(1, "drop");
    checks++; if (ack_cnt[2] !== 4) begin errors++; $display("FAIL drop_acks: got %0d required 4", ack_cnt[2]); end
    checks++; if (done_cnt[2] !== 1) begin errors++; $display("FAIL drop_done: got %0d required 1", done_cnt[2]); end
    check_rx("drop");
  endtask

  task automatic test_reset_mid_burst();
    bit to = 1'b1;
    clear_obs();
    base[0] = 8'h10; cnt[0] = 4'd5; req[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin tick(); if (ack_cnt[0] >= 1) begin to = 1'b0; break; end end
    checks++; if (to) begin errors++; $display("FAIL rstmid_first_ack: got 0 acks required 1"); end
    req[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("rstmid");
    tick(); rst = 1'b0;
    repeat (10) tick();
    checks++; if (done_total !== 0) begin errors++; $display("FAIL rstmid_done: got %0d required 0", done_total); end
    base[1] = 8'h55; cnt[1] = 4'd2; req[1] = 1'b1;
    exp_q.push_back(1*256 + 'h55); exp_q.push_back(1*256 + 'h56);
    wait_grants(2, "rstmid");
    req[1] = 1'b0;
    checks++; if (grant_log[1] !== 1) begin errors++; $display("FAIL rstmid_new_grant: got %0d required 1", grant_log[1]); end
    wait_done(1, "rstmid");
    checks++; if (ack_cnt[1] !== 2) begin errors++; $display("FAIL rstmid_acks: got %0d required 2", ack_cnt[1]); end
    check_rx("rstmid");
  endtask

  task automatic test_idle_rx();
    logic [7:0] rb;
    repeat (4) tick();
    rb = o_rx_byte;
    clear_obs();
    inj = 1'b1; tick(); inj = 1'b0;
    repeat (4) tick();
    checks++; if (rxv_n !== 0) begin errors++; $display("FAIL idle_rx_valid: got %0d pulses required 0", rxv_n); end
    checks++; if (o_rx_byte !== rb) begin errors++; $display("FAIL idle_rx_byte: got %h required %h", o_rx_byte, rb); end
  endtask

  task automatic test_invariants();
    checks++; if (oh_err !== 0) begin errors++; $display("FAIL onehot: got %0d violations required 0", oh_err); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL tx_en_spacing: got %0d violations required 0", gap_err); end
  endtask

  initial begin
    for (int k = 0; k < NR; k++) begin cnt[k] = '0; base[k] = 8'h00; end
    test_reset();
    test_single();
    test_round_robin();
    test_count_bounds();
    test_mid_drop();
    test_reset_mid_burst();
    test_idle_rx();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
